// File: rtl/booth_controller.sv
// Sequencer for a signed radix-2 Booth multiplier: WIDTH add/sub + arithmetic-shift steps per request.
// Define BOOTH_PACED_EN to pace steps from an internal tick counter (one step per DIV_VALUE+1 clocks).
module booth_controller #(
  parameter int WIDTH     = 8,
  parameter int DIV_VALUE = 4999
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  // state | meaning
  // IDLE  | waiting for start; operands captured on the accepting edge
  // RUN   | one Booth step per step enable, WIDTH steps total
  typedef enum logic {IDLE, RUN} state_t;

  localparam int SW = $clog2(WIDTH + 1);
  localparam logic [SW-1:0] LAST_STEP = SW'(WIDTH - 1);

  state_t state, state_nx;

  logic [WIDTH:0]   a_r, m_r, sum, a_sh;
  logic [WIDTH-1:0] q_r, q_sh;
  logic             q1_r, q1_sh;
  logic [SW-1:0]    step_r;
  logic             step_en, accept, last;

  assign accept = (state == IDLE) && start;
  assign last   = (step_r == LAST_STEP);

`ifdef BOOTH_PACED_EN
  localparam int TW = (DIV_VALUE > 0) ? $clog2(DIV_VALUE + 1) : 1;
  localparam logic [TW-1:0] TICK_TC = TW'(DIV_VALUE);

  logic [TW-1:0] tick_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      tick_r <= '0;
    else if (accept)
      tick_r <= '0;
    else if (state == RUN)
      tick_r <= (tick_r == TICK_TC) ? '0 : tick_r + 1'b1;
  end

  assign step_en = (state == RUN) && (tick_r == TICK_TC);
`else
  logic unused_div;
  assign unused_div = (DIV_VALUE != 0);
  assign step_en    = (state == RUN);
`endif

  // A carries an extra sign bit so subtracting M = -2^(WIDTH-1) cannot overflow.
  always_comb begin
    sum = a_r;
    unique case ({q_r[0], q1_r})
      2'b01:   sum = a_r + m_r;
      2'b10:   sum = a_r - m_r;
      default: sum = a_r;
    endcase
    a_sh  = {sum[WIDTH], sum[WIDTH:1]};
    q_sh  = {sum[0], q_r[WIDTH-1:1]};
    q1_sh = q_r[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (step_en && last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r     <= '0;
      m_r     <= '0;
      q_r     <= '0;
      q1_r    <= 1'b0;
      step_r  <= '0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        a_r    <= '0;
        m_r    <= {multiplicand[WIDTH-1], multiplicand};
        q_r    <= multiplier;
        q1_r   <= 1'b0;
        step_r <= '0;
      end else if (step_en) begin
        a_r    <= a_sh;
        q_r    <= q_sh;
        q1_r   <= q1_sh;
        step_r <= step_r + 1'b1;
        if (last) begin
          product <= {a_sh[WIDTH-1:0], q_sh};
          done    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_booth_controller.sv
// Self-checking bench for booth_controller (WIDTH=8); follows BOOTH_PACED_EN with DIV_VALUE=3 when defined.
module tb_booth_controller;
  localparam int W   = 8;
  localparam int DIV = 3;
`ifdef BOOTH_PACED_EN
  localparam int SC = DIV + 1;
`else
  localparam int SC = 1;
`endif
  localparam int LAT = W * SC;

  logic           clk, rst, start;
  logic [W-1:0]   multiplicand, multiplier;
  logic           busy, done;
  logic [2*W-1:0] product;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int busy_cnt = 0;

  // reference: a request costs LAT edges, then the signed product appears with done
  logic           m_busy, m_done;
  logic [2*W-1:0] m_prod, m_pend;
  int             m_cnt;

  booth_controller #(.WIDTH(W), .DIV_VALUE(DIV)) dut (
    .clk(clk), .rst(rst), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .busy(busy), .done(done), .product(product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_prod = '0;
      m_pend = '0;
      m_cnt  = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_prod = m_pend;
        end
      end else if (start) begin
        m_busy = 1'b1;
        m_cnt  = LAT;
        m_pend = $signed(multiplicand) * $signed(multiplier);
      end
    end
  end

  always @(negedge clk) begin
    check("busy", busy, m_busy);
    check("done", done, m_done);
    check("product", product, m_prod);
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic drive(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk);
    #1;
    start = s;
    multiplicand = a;
    multiplier = b;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < 3 * LAT + 10) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_timeout"}, done, 1'b1);
  endtask

  task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp);
    int t0, b0;
    b0 = busy_cnt;
    drive(1'b1, a, b);
    t0 = cyc + 1;
    drive(1'b0, W'($urandom), W'($urandom));
    wait_done(nm);
    check({nm, "_latency"}, cyc - t0, LAT);
    check({nm, "_product"}, product, exp);
    @(posedge clk);
    #1;
    check({nm, "_busy_cycles"}, busy_cnt - b0, LAT);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, d0;
    int dc[3];
    logic [W-1:0] ra, rb;
    logic signed [2*W-1:0] re;

    rst = 1'b1;
    start = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_product", product, 16'h0000);

    run_op("basic", 8'd3, -8'sd4, 16'hFFF4);
    check("model_basic", m_prod, 16'hFFF4);
    repeat (20) @(negedge clk);
    check("basic_hold", product, 16'hFFF4);

    run_op("neg128_sq", 8'h80, 8'h80, 16'h4000);
    run_op("p127_n128", 8'd127, 8'h80, 16'hC080);
    run_op("zero_n77", 8'd0, -8'sd77, 16'h0000);
    run_op("n1_n1", 8'hFF, 8'hFF, 16'h0001);

    // a second start while running must be ignored, not queued
    d0 = done_cnt;
    drive(1'b1, 8'd5, 8'd6);
    drive(1'b0, 8'd0, 8'd0);
    repeat (2) @(posedge clk);
    drive(1'b1, 8'd9, 8'd9);
    drive(1'b0, 8'd9, 8'd9);
    wait_done("busy_start");
    check("busy_start_product", product, 16'd30);
    repeat (25) @(posedge clk);
    #1;
    check("busy_start_single_done", done_cnt - d0, 1);

    drive(1'b1, 8'd2, 8'd3);
    t0 = cyc + 1;
    for (int i = 0; i < 3; i++) begin
      wait_done("held");
      dc[i] = cyc;
      check("held_product", product, 16'd6);
    end
    check("held_first_latency", dc[0] - t0, LAT);
    check("held_period_1", dc[1] - dc[0], LAT + 1);
    check("held_period_2", dc[2] - dc[1], LAT + 1);
    drive(1'b0, 8'd0, 8'd0);
    wait_done("held_drain");
    check("held_drain_product", product, 16'd6);

    drive(1'b1, 8'd7, 8'd7);
    drive(1'b0, 8'd0, 8'd0);
    repeat (4 * SC) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_product", product, 16'h0000);
    d0 = done_cnt;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3 * LAT) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt - d0, 0);
    run_op("after_abort", 8'd7, 8'd7, 16'd49);

    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      re = $signed(ra) * $signed(rb);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      run_op("random", ra, rb, re);
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/booth_controller.md
# booth_controller

Sequencing controller for the signed radix-2 Booth multiplier. It accepts a start request with two signed operands and walks the add/subtract/arithmetic-shift datapath through exactly WIDTH iterations, then presents the 2·WIDTH-bit product with a one-cycle done strobe. Step pacing can come from an internal tick counter, so results can be observed at human speed on the board without gating the system clock.

## Interface
- WIDTH, 8: operand width in bits, two's complement, minimum 2.
- DIV_VALUE, 4999: tick counter terminal value; one tick every DIV_VALUE+1 clocks. Used only when pacing is compiled in.

- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- multiplicand  in  WIDTH  signed M; captured on the accepting edge.
- multiplier  in  WIDTH  signed Q; captured on the accepting edge.
- busy  out  1  high while in RUN.
- done  out  1  single-cycle pulse when the product is updated.
- product  out  2·WIDTH  signed result; holds until the next completion.

## Operation
- Internal registers:
  - A: WIDTH+1 bits, sign-extended, so M = −2^(WIDTH−1) cannot overflow.
  - Q: WIDTH bits.
  - q_1: 1 bit.
  - M: WIDTH+1 bits, sign-extended.
  - step counter: clog2(WIDTH+1) bits.
  - tick counter: integer range 0..DIV_VALUE.
- States:
  - IDLE: busy=0. On start=1, load A=0, Q=multiplier, q_1=0, M=multiplicand, step=0, tick counter=0, then go to RUN.
  - RUN: busy=1. On each step enable, apply the step rule below, then step+1.
    - Step rule on {Q[0],q_1}: 01 → A=A+M; 10 → A=A−M; 00/11 → no add.
    - Then arithmetic shift right of {A,Q,q_1} by one, replicating A's MSB.
    - The step that brings step to WIDTH also writes product = {A[WIDTH−1:0],Q} from the post-shift value, sets done=1, and returns to IDLE.
- done is high only during the cycle after the final step. That cycle is IDLE, so a start in it is accepted.
- start while in RUN is ignored. It is not queued and the operands are not recaptured.
- Operand inputs may change freely after the accepting edge.

## Timing
- Reset values:
  - busy=0, done=0, product=0.
  - State IDLE; all internal registers 0.
- Reset mid-operation aborts immediately. There is no done pulse and product returns to 0.
- Unpaced:
  - start is sampled at edge k.
  - Steps occur at edges k+1 … k+WIDTH.
  - done is high in the cycle after edge k+WIDTH.
- Paced:
  - The tick counter runs only in RUN and wraps DIV_VALUE→0.
  - Step enable is counter==DIV_VALUE.
  - Step n occurs at edge k+n·(DIV_VALUE+1).
  - done follows edge k+WIDTH·(DIV_VALUE+1).
- Back-to-back:
  - start held high continuously gives one result every WIDTH+1 edges when unpaced.
  - The busy gap is exactly the done cycle.

## Configuration
- BOOTH_PACED_EN defined:
  - Step enable comes from the internal tick counter, giving one Booth step per DIV_VALUE+1 clocks.
- BOOTH_PACED_EN undefined:
  - The tick counter is not synthesized and DIV_VALUE is unused.
  - Step enable is constantly 1 in RUN, giving one step per clock.

## Test plan
- Bench uses WIDTH=8 with BOOTH_PACED_EN undefined unless a case states otherwise.
- Basic product:
  - M=3, Q=−4, pulse start → done exactly 8 edges after the accepting edge.
  - product=16'hFFF4, and it holds 16'hFFF4 for 20 further idle cycles.
- Corner operands:
  - −128×−128 → 16'h4000.
  - 127×−128 → 16'hC080.
  - 0×−77 → 16'h0000.
  - −1×−1 → 16'h0001.
- Start while busy:
  - M=5, Q=6, then a start pulse mid-RUN with M=9, Q=9 → single done, product=16'd30.
  - Next result only after a new start.
- Start held high:
  - Operands 2×3 → done every 9th edge, product=6.
  - busy is low only in done cycles.
- Reset mid-operation:
  - Assert rst 4 steps into 7×7 → busy=0, done=0, product=0 asynchronously.
  - No done pulse.
  - A subsequent 7×7 gives 16'd49.
- Paced mode:
  - Define BOOTH_PACED_EN with DIV_VALUE=3; M=−6, Q=5 → done 32 edges after the accepting edge.
  - product=16'hFFE2.
  - busy high for 32 cycles.
